// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if
//   Bundles the CPU-facing signals of the HI/LO multiply/divide unit.
//   master : CPU/decoder side. Drives start/op/operands/move requests
//            and observes results and stall.
//   slave  : the mdu_hilo unit itself.
//   Signals
//     start   begin mult/div described by op, srca, srcb
//     op      00 mult, 01 multu, 10 div, 11 divu
//     srca    multiplicand / dividend
//     srcb    multiplier / divisor
//     mt      move-to request (mthi/mtlo), data on wd
//     mf      move-from request (mfhi/mflo), result on rdata
//     spaddr  0 selects LO, 1 selects HI for mt and mf
//     wd      move-to data
//     rdata   spaddr ? hi : lo, combinational
//     hi, lo  HI and LO registers
//     busy    operation in progress
//     stall   busy and the CPU is requesting the unit
//     done    one-cycle pulse when new HI/LO first become visible
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             mt;
  logic             mf;
  logic             spaddr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;

  modport master (
    output start, op, srca, srcb, mt, mf, spaddr, wd,
    input  rdata, hi, lo, busy, stall, done
  );

  modport slave (
    input  start, op, srca, srcb, mt, mf, spaddr, wd,
    output rdata, hi, lo, busy, stall, done
  );
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo
//   Iterative multiply/divide unit that owns the HI/LO special registers.
//   One shift-add (multiply) or restoring-subtract (divide) step is taken
//   per clock; the CPU is frozen through stall while the unit is busy.
//   Signed operations run on operand magnitudes and the signs are applied
//   in a final FIX cycle.
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-high; aborts any operation, clears HI/LO
//     bus    mdu_hilo_if.slave (see interface file for signal list)
//   Timing
//     start sampled at edge E0 -> busy for WIDTH+1 cycles -> HI/LO written
//     and done pulsed at edge E(WIDTH+1).
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mdu_hilo_if.slave   bus
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Shared iteration registers:
  //   multiply: rem_reg = running upper product, q_reg = multiplier that
  //             shifts out on the right while product bits shift in,
  //             b_reg = multiplicand magnitude
  //   divide  : rem_reg = partial remainder (WIDTH+1 bits because the
  //             shifted remainder can reach 2*divisor-1), q_reg = dividend
  //             shifting out on the left / quotient shifting in,
  //             b_reg = divisor magnitude
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count_reg;
  logic             div_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             div_zero_reg;

  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             done_reg;

  // ------------------------------------------------------------------
  // Operand conditioning at start
  // ------------------------------------------------------------------
  logic             is_signed;
  logic             is_div;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    is_signed = ~bus.op[0];
    is_div    = bus.op[1];
    neg_a     = is_signed & bus.srca[WIDTH-1];
    neg_b     = is_signed & bus.srcb[WIDTH-1];
    // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude
    a_mag     = neg_a ? (~bus.srca + WIDTH'(1)) : bus.srca;
    b_mag     = neg_b ? (~bus.srcb + WIDTH'(1)) : bus.srcb;
  end

  // ------------------------------------------------------------------
  // One iteration step
  // ------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;

  always_comb begin
    mul_sum   = q_reg[0] ? (rem_reg + {1'b0, b_reg}) : rem_reg;
    div_shift = {rem_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    div_ge    = (div_shift >= {1'b0, b_reg});
    if (div_reg) begin
      rem_step = div_ge ? div_diff : div_shift;
      q_step   = {q_reg[WIDTH-2:0], div_ge};
    end else begin
      // product shifts right one bit: LSB of the sum enters the low half
      rem_step = {1'b0, mul_sum[WIDTH:1]};
      q_step   = {mul_sum[0], q_reg[WIDTH-1:1]};
    end
  end

  // ------------------------------------------------------------------
  // Sign correction for the FIX cycle
  // ------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod_mag = {rem_reg[WIDTH-1:0], q_reg};
    prod_fix = neg_q_reg ? (~prod_mag + (2*WIDTH)'(1)) : prod_mag;

    if (div_zero_reg) begin
      quo_fix = '1;
    end else if (neg_q_reg) begin
      quo_fix = ~q_reg + WIDTH'(1);
    end else begin
      quo_fix = q_reg;
    end

    // With a zero divisor the remainder path accumulates |srca|; restoring
    // the dividend sign yields srca unchanged, which is the required HI.
    rem_fix = neg_r_reg ? (~rem_reg[WIDTH-1:0] + WIDTH'(1)) : rem_reg[WIDTH-1:0];

    if (div_reg) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (count_reg == LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath and HI/LO
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg      <= '0;
      q_reg        <= '0;
      b_reg        <= '0;
      count_reg    <= '0;
      div_reg      <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= (state_reg == FIX);
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            // start takes priority over a simultaneous move-to
            rem_reg      <= '0;
            q_reg        <= is_div ? a_mag : b_mag;
            b_reg        <= is_div ? b_mag : a_mag;
            count_reg    <= '0;
            div_reg      <= is_div;
            neg_q_reg    <= neg_a ^ neg_b;
            neg_r_reg    <= neg_a;
            div_zero_reg <= is_div & (bus.srcb == '0);
          end else if (bus.mt) begin
            if (bus.spaddr) begin
              hi_reg <= bus.wd;
            end else begin
              lo_reg <= bus.wd;
            end
          end
        end
        CALC: begin
          rem_reg   <= rem_step;
          q_reg     <= q_step;
          count_reg <= count_reg + CW'(1);
        end
        FIX: begin
          hi_reg <= fix_hi;
          lo_reg <= fix_lo;
        end
        default: begin
        end
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  logic busy_int;

  assign busy_int  = (state_reg != IDLE);
  assign bus.busy  = busy_int;
  // HI/LO only change in FIX, so a read during busy sees pre-operation values
  assign bus.rdata = bus.spaddr ? hi_reg : lo_reg;
  assign bus.hi    = hi_reg;
  assign bus.lo    = lo_reg;
  assign bus.stall = busy_int & (bus.start | bus.mt | bus.mf);
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_hilo_if #(.WIDTH(W)) bus();

  mdu_hilo #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain 64-bit integer math on the operands.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: begin
        q = sa * sb;
        return 64'(q);
      end
      2'b01: begin
        p = ua * ub;
        return p;
      end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Behavioural model: idle/busy countdown plus pending result.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_cnt;
  logic        m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          m_cnt <= W + 1;
          {p_hi, p_lo} <= ref_result(bus.op, bus.srca, bus.srcb);
        end else if (bus.mt) begin
          if (bus.spaddr) m_hi <= bus.wd;
          else            m_lo <= bus.wd;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi   <= p_hi;
          m_lo   <= p_lo;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_hi",    {32'd0, bus.hi},    {32'd0, m_hi});
      check("cyc_lo",    {32'd0, bus.lo},    {32'd0, m_lo});
      check("cyc_busy",  {63'd0, bus.busy},  {63'd0, (m_cnt != 0)});
      check("cyc_done",  {63'd0, bus.done},  {63'd0, m_done});
      check("cyc_stall", {63'd0, bus.stall},
            {63'd0, (m_cnt != 0) & (bus.start | bus.mt | bus.mf)});
      check("cyc_rdata", {32'd0, bus.rdata}, {32'd0, bus.spaddr ? m_hi : m_lo});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && bus.busy; i++) tick();
  endtask

  // Issue one op, measure latency and busy length, check literal results.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name, input logic [31:0] ehi, input logic [31:0] elo);
    int n, nb;
    wait_idle();
    bus.op    = op;
    bus.srca  = a;
    bus.srcb  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n  = 0;
    nb = bus.busy ? 1 : 0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
      if (bus.busy) nb++;
    end
    check({name, "_latency"}, 64'(n), 64'd33);
    check({name, "_busycyc"}, 64'(nb), 64'd33);
    check({name, "_hi"}, {32'd0, bus.hi}, {32'd0, ehi});
    check({name, "_lo"}, {32'd0, bus.lo}, {32'd0, elo});
    $display("op %s a=%h b=%h -> hi=%h lo=%h", name, a, b, bus.hi, bus.lo);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.srca   = '0;
    bus.srcb   = '0;
    bus.mt     = 1'b0;
    bus.mf     = 1'b0;
    bus.spaddr = 1'b0;
    bus.wd     = '0;

    tick();
    cmp_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_hi",   {32'd0, bus.hi}, 64'd0);
    check("rst_lo",   {32'd0, bus.lo}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);

    run_op(2'b00, 32'd7,         32'hFFFF_FFFD, "mult_7_m3",   32'hFFFF_FFFF, 32'hFFFF_FFEB);
    // back-to-back: next start lands in the done cycle
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max",   32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'b11, 32'd100,       32'd7,         "divu_100_7",  32'd2,         32'd14);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_m7_2",    32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",     32'd0,         32'h8000_0000);
    run_op(2'b10, 32'd7,         32'hFFFF_FFFE, "div_7_m2",    32'd1,         32'hFFFF_FFFD);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0,         "div_m5_0",    32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min",    32'h4000_0000, 32'd0);
    run_op(2'b11, 32'd5,         32'd0,         "divu_5_0",    32'd5,         32'hFFFF_FFFF);

    // mthi then mfhi; LO must stay at the divu_5_0 quotient
    bus.mt = 1'b1; bus.spaddr = 1'b1; bus.wd = 32'h0000_1234;
    tick();
    bus.mt = 1'b0; bus.mf = 1'b1;
    #1;
    check("mfhi_rdata", {32'd0, bus.rdata}, 64'h1234);
    check("mthi_lo",    {32'd0, bus.lo},    64'hFFFF_FFFF);
    $display("mthi/mfhi rdata=%h lo=%h", bus.rdata, bus.lo);
    bus.mf = 1'b0;
    bus.mt = 1'b1; bus.spaddr = 1'b0; bus.wd = 32'h0000_ABCD;
    tick();
    bus.mt = 1'b0;
    check("mtlo_lo", {32'd0, bus.lo}, 64'hABCD);
    check("mtlo_hi", {32'd0, bus.hi}, 64'h1234);
    $display("mtlo lo=%h hi=%h", bus.lo, bus.hi);

    // start and mt together: start wins, LO not written by mt
    bus.op = 2'b01; bus.srca = 32'd3; bus.srcb = 32'd5;
    bus.start = 1'b1; bus.mt = 1'b1; bus.spaddr = 1'b0; bus.wd = 32'h0000_DEAD;
    tick();
    bus.start = 1'b0; bus.mt = 1'b0;
    check("startmt_busy", {63'd0, bus.busy}, 64'd1);
    check("startmt_lo",   {32'd0, bus.lo},   64'hABCD);
    for (int i = 0; i < 100 && !bus.done; i++) tick();
    check("startmt_res", {bus.hi, bus.lo}, 64'd15);
    $display("start+mt -> hi=%h lo=%h", bus.hi, bus.lo);

    // mf and a second start while busy: stall, pre-op rdata, second start ignored
    wait_idle();
    bus.op = 2'b01; bus.srca = 32'd6; bus.srcb = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    bus.mf = 1'b1; bus.spaddr = 1'b0;
    bus.start = 1'b1; bus.op = 2'b01; bus.srca = 32'd9; bus.srcb = 32'd9;
    #1;
    check("busy_stall", {63'd0, bus.stall}, 64'd1);
    check("busy_rdata", {32'd0, bus.rdata}, 64'd15);
    tick();
    bus.start = 1'b0; bus.mf = 1'b0;
    for (int i = 0; i < 100 && !bus.done; i++) tick();
    check("busy_res", {bus.hi, bus.lo}, 64'd42);
    tick();
    check("busy_no_restart", {63'd0, bus.busy}, 64'd0);
    $display("stall test -> hi=%h lo=%h", bus.hi, bus.lo);

    // reset in the middle of a divide
    bus.op = 2'b10; bus.srca = 32'd100; bus.srcb = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    check("abort_hi",   {32'd0, bus.hi}, 64'd0);
    check("abort_lo",   {32'd0, bus.lo}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    $display("abort -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    tick();
    reset = 1'b0;
    tick();
    run_op(2'b11, 32'd100, 32'd7, "after_abort", 32'd2, 32'd14);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
